clock_enable_gen: RTL and testbench

Parametrised multi-channel tick generator. It replaces the free-running divider whose individual bits are used directly as derived clocks. The block runs in the single system clock domain and produces per-channel one-cycle enable pulses (tick) plus 50%-duty level outputs with runtime-programmable divisors. It also keeps a free-running cycle counter for legacy consumers and sits at top level, feeding the view, editor and keyboard blocks.

---
 rtl/clock_enable_gen.sv | 138 +++++++++++++
 tb/tb_clock_enable_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clock_enable_gen
// Purpose  : Multi-channel tick generator in the single system clock domain.
//            Each channel produces a one-cycle enable pulse every div cycles
//            and a square wave that toggles on every tick. A free-running
//            cycle counter is kept alongside for legacy consumers.
// Ports    : clk_100mhz - system clock (sole clock)
//            reset      - synchronous, active-high reset
//            cfg_we     - divisor write strobe (one cycle)
//            cfg_ch     - channel addressed by the write
//            cfg_div    - new divisor, 0 disables the channel
//            sync       - (only with CLOCK_ENABLE_GEN_SYNC_EN) phase-align
//                         all channels and clear their levels
//            tick       - per-channel one-cycle enable pulse (registered)
//            level      - per-channel square wave (registered)
//            cycle_cnt  - free-running cycle counter (registered)
// Macro    : CLOCK_ENABLE_GEN_SYNC_EN enables the sync input and alignment.
// Revision : 1.0 - initial release
// ============================================================================
module clock_enable_gen #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 4
) (
   input  logic              clk_100mhz,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
   input  logic              sync,
`endif
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] level,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

   // -------------------------------------------------------------------------
   // Free-running cycle counter, wraps naturally at 2^CNT_W.
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] cycle_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q + c_one;
   end

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         cycle_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;

   // -------------------------------------------------------------------------
   // Per-channel divider. Write addresses outside 0..NUM_CH-1 match no
   // channel and are therefore dropped without any state change.
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] div_q;
      logic [CNT_W-1:0] div_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             tick_q;
      logic             tick_d;
      logic             level_q;
      logic             level_d;
      logic             wr_w;
      logic             term_w;

      assign wr_w   = cfg_we && (cfg_ch == CH_W'(i));
      // Zero divisor is excluded first so div_q-1 never wraps into a match.
      assign term_w = (div_q != '0) && (cnt_q == (div_q - c_one));

      always_comb begin
         div_d   = div_q;
         cnt_d   = cnt_q;
         tick_d  = 1'b0;
         level_d = level_q;

         if (div_q == '0) begin
            cnt_d = '0;
         end else if (term_w) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + c_one;
         end

         // A write restarts the phase and suppresses a coinciding tick;
         // the square wave must not toggle on that edge either.
         if (wr_w) begin
            div_d   = cfg_div;
            cnt_d   = '0;
            tick_d  = 1'b0;
            level_d = level_q;
         end

`ifdef CLOCK_ENABLE_GEN_SYNC_EN
         // Alignment is applied after the write so a simultaneous write keeps
         // its new divisor while the phase and level still restart.
         if (sync) begin
            cnt_d   = '0;
            tick_d  = 1'b0;
            level_d = 1'b0;
         end
`endif
      end

      always_ff @(posedge clk_100mhz) begin
         if (reset) begin
            div_q   <= c_default_div;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
         end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
         end
      end

      assign tick[i]  = tick_q;
      assign level[i] = level_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_enable_gen
// Purpose  : Self-checking bench for clock_enable_gen (3 channels, 4-bit
//            counters so cycle_cnt wraps and out-of-range channel writes
//            are reachable). Expected values come from a cycle-level model
//            that counts edges since each channel's last restart.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_enable_gen;

   localparam int NUM_CH      = 3;
   localparam int CH_W        = 2;
   localparam int CNT_W       = 4;
   localparam int DEFAULT_DIV = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cfg_we = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] level;
   logic [CNT_W-1:0]  cycle_cnt;

   int n_total = 0;
   int n_bad   = 0;

   // Reference state: divisor, edges elapsed since the last (re)start,
   // expected tick/level and expected cycle counter.
   int m_div [NUM_CH];
   int m_el  [NUM_CH];
   bit m_tick[NUM_CH];
   bit m_lvl [NUM_CH];
   int m_cyc;

   always #5 clk = ~clk;

   clock_enable_gen #(
      .NUM_CH      (NUM_CH),
      .CH_W        (CH_W),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk_100mhz (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
`ifdef CLOCK_ENABLE_GEN_SYNC_EN
      .sync       (1'b0),
`endif
      .tick       (tick),
      .level      (level),
      .cycle_cnt  (cycle_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit we, input int ch, input int dv);
      if (rst) begin
         m_cyc = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEFAULT_DIV; m_el[i] = 0; m_tick[i] = 0; m_lvl[i] = 0;
         end
      end else begin
         m_cyc = (m_cyc + 1) % (1 << CNT_W);
         for (int i = 0; i < NUM_CH; i++) begin
            if (we && ch == i) begin
               m_div[i] = dv; m_el[i] = 0; m_tick[i] = 0;
            end else if (m_div[i] == 0) begin
               m_tick[i] = 0;
            end else begin
               m_el[i]++;
               m_tick[i] = (m_el[i] % m_div[i]) == 0;
               if (m_tick[i]) m_lvl[i] = ~m_lvl[i];
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance DUT and model, then compare.
   task automatic cyc(input bit rst, input bit we, input int ch, input int dv);
      logic [NUM_CH-1:0] et;
      logic [NUM_CH-1:0] el;
      reset   = rst;
      cfg_we  = we;
      cfg_ch  = CH_W'(ch);
      cfg_div = CNT_W'(dv);
      @(posedge clk);
      model_step(rst, we, ch, dv);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         et[i] = m_tick[i];
         el[i] = m_lvl[i];
      end
      check_eq("tick", 32'(tick), 32'(et));
      check_eq("level", 32'(level), 32'(el));
      check_eq("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
      reset  = 1'b0;
      cfg_we = 1'b0;
   endtask

   initial begin
      bit found;
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = DEFAULT_DIV; m_el[i] = 0; m_tick[i] = 0; m_lvl[i] = 0;
      end
      m_cyc = 0;

      // Reset, then defaults: ticks together every 4, level period 8.
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0);

      // ch1 div=1 (continuous tick), ch2 div=0 (frozen).
      cyc(0, 1, 1, 1);
      cyc(0, 1, 2, 0);
      for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0);

      // Rewrite ch0 to 3 on the edge where it would have ticked.
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (m_div[0] != 0 && ((m_el[0] + 1) % m_div[0]) == 0) found = 1;
         else cyc(0, 0, 0, 0);
      end
      check_eq("align_found", 32'(found), 32'd1);
      cyc(0, 1, 0, 3);
      for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0);

      // Out-of-range channel write must be ignored.
      cyc(0, 1, 3, 7);
      for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0);

      // Reset with a simultaneous write: write discarded.
      cyc(1, 1, 0, 9);
      for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         int dv;
         dv = int'($urandom % 8);
         if ($urandom % 10 == 0) dv = int'($urandom % 16);
         cyc(($urandom % 97) == 0, ($urandom % 6) == 0, int'($urandom % 4), dv);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
